// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD job sequencer and the subtractive GCD core.
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    ABORT   = 3'd4,
    OUT     = 3'd5
  } seq_state_t;

  localparam int DEFAULT_NUM_WIDTH = 8;

  // Comparator codes used by the core's A/B compare stage.
  localparam logic [1:0] CMP_EQ = 2'd0;
  localparam logic [1:0] CMP_LT = 2'd1;
  localparam logic [1:0] CMP_GT = 2'd2;

endpackage

// File: rtl/gcd_job_sequencer_if.sv
// Operand-in / result-out valid/ready streams of the GCD job sequencer.
interface gcd_job_sequencer_if
  import gcd_pkg::*;
#(
  parameter int NUM_WIDTH = DEFAULT_NUM_WIDTH
);

  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_WIDTH-1:0] in_a;
  logic [NUM_WIDTH-1:0] in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [NUM_WIDTH-1:0] out_data;
  logic                 out_err;

  // master: the producer of operands and consumer of results
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

endinterface

// File: rtl/gcd_watchdog.sv
// Loadable cycle counter with clear, enable and terminal-count flag at TIMEOUT_CYCLES-1.
module gcd_watchdog #(
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int CW             = $clog2(TIMEOUT_CYCLES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          tc
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/gcd_job_sequencer.sv
// Feeds operand pairs to an external subtractive GCD core and returns its results,
// bypassing zero operands and aborting runaway jobs with a watchdog.
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int NUM_WIDTH      = DEFAULT_NUM_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gcd_job_sequencer_if.slave   stream,
  output logic                 core_start,
  output logic [NUM_WIDTH-1:0] core_a,
  output logic [NUM_WIDTH-1:0] core_b,
  output logic                 core_rst,
  input  logic                 core_done,
  input  logic [NUM_WIDTH-1:0] core_res,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] jobs_done
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  seq_state_t state, state_nxt;
  logic       wd_clr;
  logic       wd_en;
  logic       wd_tc;
  logic       zero_op;

  // gcd(0,x) = x and gcd(0,0) = 0, so OR-ing the operands gives the answer.
  function automatic logic [NUM_WIDTH-1:0] bypass_result(
    input logic [NUM_WIDTH-1:0] a,
    input logic [NUM_WIDTH-1:0] b
  );
    return a | b;
  endfunction

  gcd_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (wd_clr),
    .load     (1'b0),
    .load_val ({CW{1'b0}}),
    .en       (wd_en),
    .tc       (wd_tc)
  );

  assign zero_op  = (stream.in_a == '0) || (stream.in_b == '0);
  assign busy     = (state != IDLE);
  assign core_rst = ~rst_n | (state == ABORT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    stream.in_ready  = 1'b0;
    stream.out_valid = 1'b0;
    core_start       = 1'b0;
    wd_clr           = 1'b0;
    wd_en            = 1'b0;
    case (state)
      IDLE: begin
        stream.in_ready = 1'b1;
        if (stream.in_valid) begin
          state_nxt = zero_op ? OUT : START;
        end
      end
      START: begin
        core_start = 1'b1;
        wd_clr     = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        wd_en = 1'b1;
        // Done wins over a timeout that lands in the same cycle.
        if (core_done) begin
          state_nxt = CAPTURE;
        end else if (wd_tc) begin
          state_nxt = ABORT;
        end
      end
      CAPTURE: state_nxt = OUT;
      ABORT:   state_nxt = OUT;
      OUT: begin
        stream.out_valid = 1'b1;
        if (stream.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands stay on the core from acceptance until the next acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_a          <= '0;
      core_b          <= '0;
      stream.out_data <= '0;
      stream.out_err  <= 1'b0;
      jobs_done       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (stream.in_valid) begin
            core_a <= stream.in_a;
            core_b <= stream.in_b;
            if (zero_op) begin
              stream.out_data <= bypass_result(stream.in_a, stream.in_b);
              stream.out_err  <= 1'b0;
            end
          end
        end
        CAPTURE: begin
          stream.out_data <= core_res;
          stream.out_err  <= 1'b0;
        end
        ABORT: begin
          stream.out_data <= '0;
          stream.out_err  <= 1'b1;
        end
        OUT: begin
          if (stream.out_ready) begin
            jobs_done <= jobs_done + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Directed bench for gcd_job_sequencer with a behavioural subtractive GCD core attached.
module tb_gcd_job_sequencer;
  import gcd_pkg::*;

  localparam int NW = 8;
  localparam int TO = 16;
  localparam int CWID = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            core_start, core_rst, core_done, busy;
  logic [NW-1:0]   core_a, core_b, core_res;
  logic [CWID-1:0] jobs_done;

  int errors = 0;
  int checks = 0;

  // 0: behavioural core, 1: done never rises, 2: done/res driven by the bench
  int            mode = 0;
  logic          stub_done = 1'b0;
  logic [NW-1:0] stub_res  = '0;

  gcd_job_sequencer_if #(.NUM_WIDTH(NW)) sif ();

  gcd_job_sequencer #(
    .NUM_WIDTH(NW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CWID)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stream(sif.slave),
    .core_start(core_start), .core_a(core_a), .core_b(core_b),
    .core_rst(core_rst), .core_done(core_done), .core_res(core_res),
    .busy(busy), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  // Behavioural core: load the cycle after start, compare, subtract, done, res next cycle.
  typedef enum logic [2:0] {M_IDLE, M_LOAD, M_CMP, M_SUB, M_DONE} m_state_t;
  m_state_t      m_st;
  logic [NW-1:0] ra, rb, m_res;
  logic [1:0]    cmp;

  assign cmp = (ra == rb) ? CMP_EQ : ((ra < rb) ? CMP_LT : CMP_GT);

  always_ff @(posedge clk) begin
    if (core_rst) begin
      m_st  <= M_IDLE;
      ra    <= '0;
      rb    <= '0;
      m_res <= '0;
    end else begin
      case (m_st)
        M_IDLE: if (core_start) m_st <= M_LOAD;
        M_LOAD: begin ra <= core_a; rb <= core_b; m_st <= M_CMP; end
        M_CMP:  m_st <= (cmp == CMP_EQ) ? M_DONE : M_SUB;
        M_SUB: begin
          if (cmp == CMP_GT) ra <= ra - rb;
          else               rb <= rb - ra;
          m_st <= M_CMP;
        end
        M_DONE: begin m_res <= ra; m_st <= M_IDLE; end
        default: m_st <= M_IDLE;
      endcase
    end
  end

  always_comb begin
    core_done = 1'b0;
    core_res  = m_res;
    if (mode == 0) begin
      core_done = (m_st == M_DONE);
    end else if (mode == 2) begin
      core_done = stub_done;
      core_res  = stub_res;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a pair until accepted; returns in cycle 1 (cycle 0 is the handshake).
  task automatic send(input logic [NW-1:0] a, input logic [NW-1:0] b);
    int n = 0;
    while (!sif.in_ready && n < 50) begin tick(); n++; end
    checks++;
    if (sif.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b required 1", sif.in_ready);
    end
    sif.in_valid = 1'b1; sif.in_a = a; sif.in_b = b;
    tick();
    sif.in_valid = 1'b0;
  endtask

  // Cycle index (from 1) at which out_valid appears, -1 if it never does.
  task automatic wait_out(output int cyc, output int starts);
    bit found = 0;
    cyc = -1; starts = 0;
    for (int i = 1; i <= 100 && !found; i++) begin
      if (core_start) starts++;
      if (sif.out_valid) begin cyc = i; found = 1; end
      else tick();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sif.in_valid = 1'b0; sif.in_a = '0; sif.in_b = '0; sif.out_ready = 1'b0;
    tick(); tick();
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL rst_core_rst: got %b need 1", core_rst); end
    checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b need 0", sif.out_valid); end
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL rst_core_start: got %b need 0", core_start); end
    checks++; if ({core_a, core_b} !== 16'h0) begin errors++; $display("FAIL rst_core_ab: got %h need 0", {core_a, core_b}); end
    checks++; if ({sif.out_err, sif.out_data} !== 9'h0) begin errors++; $display("FAIL rst_out: got %h need 0", {sif.out_err, sif.out_data}); end
    checks++; if (jobs_done !== 16'd0) begin errors++; $display("FAIL rst_jobs: got %0d need 0", jobs_done); end
    rst_n = 1'b1;
    tick();
    checks++; if (sif.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b need 1", sif.in_ready); end
    checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL rst_core_rst_rel: got %b need 0", core_rst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b need 0", busy); end
  endtask

  task automatic test_normal;
    int cyc, starts;
    sif.out_ready = 1'b1;
    send(8'd12, 8'd8);
    checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL norm_start_c1: got %b need 1", core_start); end
    wait_out(cyc, starts);
    checks++; if (cyc != 10) begin errors++; $display("FAIL norm_latency: got %0d need 10", cyc); end
    checks++; if (starts != 1) begin errors++; $display("FAIL norm_starts: got %0d need 1", starts); end
    checks++; if (sif.out_data !== 8'd4) begin errors++; $display("FAIL norm_data: got %0d need 4", sif.out_data); end
    checks++; if (sif.out_err !== 1'b0) begin errors++; $display("FAIL norm_err: got %b need 0", sif.out_err); end
    tick();
    checks++; if (jobs_done !== 16'd1) begin errors++; $display("FAIL norm_jobs: got %0d need 1", jobs_done); end
    checks++; if (sif.in_ready !== 1'b1) begin errors++; $display("FAIL norm_in_ready: got %b need 1", sif.in_ready); end
  endtask

  task automatic test_zero_bypass;
    logic [NW-1:0] va [2] = '{8'd9, 8'd0};
    for (int k = 0; k < 2; k++) begin
      send(8'd0, va[k]);
      checks++; if (sif.out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid_%0d: got %b need 1", k, sif.out_valid); end
      checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL zero_start_%0d: got %b need 0", k, core_start); end
      checks++; if (sif.out_data !== va[k]) begin errors++; $display("FAIL zero_data_%0d: got %0d need %0d", k, sif.out_data, va[k]); end
      checks++; if (core_b !== va[k]) begin errors++; $display("FAIL zero_core_b_%0d: got %0d need %0d", k, core_b, va[k]); end
      tick();
      checks++; if (jobs_done !== 16'(2 + k)) begin errors++; $display("FAIL zero_jobs_%0d: got %0d need %0d", k, jobs_done, 2 + k); end
    end
  endtask

  task automatic test_back_pressure;
    int cyc, starts;
    sif.out_ready = 1'b0;
    send(8'd6, 8'd6);
    wait_out(cyc, starts);
    checks++; if (cyc != 6) begin errors++; $display("FAIL bp_latency: got %0d need 6", cyc); end
    // A new pair waits upstream while the result is stalled.
    sif.in_valid = 1'b1; sif.in_a = 8'd0; sif.in_b = 8'd5;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({sif.out_valid, sif.in_ready, sif.out_data} !== {1'b1, 1'b0, 8'd6}) begin
        errors++; $display("FAIL bp_hold_%0d: valid/ready/data %b/%b/%0d need 1/0/6", i, sif.out_valid, sif.in_ready, sif.out_data);
      end
      tick();
    end
    sif.out_ready = 1'b1;
    tick();
    checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL bp_one_xfer: got %b need 0", sif.out_valid); end
    checks++; if (sif.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready: got %b need 1", sif.in_ready); end
    checks++; if (jobs_done !== 16'd4) begin errors++; $display("FAIL bp_jobs: got %0d need 4", jobs_done); end
    tick();
    sif.in_valid = 1'b0;
    checks++; if (sif.out_data !== 8'd5 || sif.out_valid !== 1'b1) begin errors++; $display("FAIL bp_held_pair: data %0d valid %b need 5 1", sif.out_data, sif.out_valid); end
    tick();
    checks++; if (jobs_done !== 16'd5) begin errors++; $display("FAIL bp_jobs2: got %0d need 5", jobs_done); end
  endtask

  task automatic test_timeout;
    int rst_cnt = 0;
    int cyc = -1;
    mode = 1;
    send(8'd7, 8'd3);
    for (int i = 1; i <= 40 && cyc < 0; i++) begin
      if (core_rst) rst_cnt++;
      if (sif.out_valid) cyc = i;
      else tick();
    end
    checks++; if (cyc != 19) begin errors++; $display("FAIL to_latency: got %0d need 19", cyc); end
    checks++; if (rst_cnt != 1) begin errors++; $display("FAIL to_core_rst_cycles: got %0d need 1", rst_cnt); end
    checks++; if (sif.out_data !== 8'd0) begin errors++; $display("FAIL to_data: got %0d need 0", sif.out_data); end
    checks++; if (sif.out_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b need 1", sif.out_err); end
    tick();
    checks++; if (jobs_done !== 16'd6) begin errors++; $display("FAIL to_jobs: got %0d need 6", jobs_done); end
    mode = 0;
  endtask

  task automatic test_done_on_terminal;
    mode = 2; stub_res = 8'hA5;
    send(8'd5, 8'd5);
    for (int i = 0; i < 16; i++) tick();
    stub_done = 1'b1;
    tick();
    stub_done = 1'b0;
    checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL term_no_abort: core_rst %b need 0", core_rst); end
    tick();
    checks++; if (sif.out_valid !== 1'b1) begin errors++; $display("FAIL term_valid: got %b need 1", sif.out_valid); end
    checks++; if (sif.out_data !== 8'hA5) begin errors++; $display("FAIL term_data: got %h need a5", sif.out_data); end
    checks++; if (sif.out_err !== 1'b0) begin errors++; $display("FAIL term_err: got %b need 0", sif.out_err); end
    tick();
    mode = 0;
  endtask

  task automatic test_reset_mid_job;
    int cyc, starts;
    send(8'd255, 8'd1);
    tick(); tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b need 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_rst: got %b need 0", busy); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL mid_core_rst: got %b need 1", core_rst); end
    checks++; if ({core_a, core_b} !== 16'h0) begin errors++; $display("FAIL mid_core_ab: got %h need 0", {core_a, core_b}); end
    checks++; if (jobs_done !== 16'd0) begin errors++; $display("FAIL mid_jobs: got %0d need 0", jobs_done); end
    tick(); tick();
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL mid_core_rst_held: got %b need 1", core_rst); end
    rst_n = 1'b1;
    tick();
    send(8'd9, 8'd6);
    wait_out(cyc, starts);
    checks++; if (cyc != 10) begin errors++; $display("FAIL mid_latency: got %0d need 10", cyc); end
    checks++; if (sif.out_data !== 8'd3) begin errors++; $display("FAIL mid_data: got %0d need 3", sif.out_data); end
    tick();
    checks++; if (jobs_done !== 16'd1) begin errors++; $display("FAIL mid_jobs_after: got %0d need 1", jobs_done); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_zero_bypass();
    test_back_pressure();
    test_timeout();
    test_done_on_terminal();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
